// File: rtl/pu_riscv_bu_ras_if.sv
// Branch-unit bus: ID/EX instruction, operands and control in; redirect, predictor feedback and RAS status out.
interface pu_riscv_bu_ras_if #(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned BP_GLOBAL_BITS = 2
);
    logic                      ex_stall;
    logic                      st_flush;
    logic                      du_stall;
    logic                      du_we_pc;
    logic [XLEN-1:0]           du_dato;
    logic                      id_bubble;
    logic [XLEN-1:0]           id_pc;
    logic [31:0]               id_instr;
    logic                      id_is_rvc;
    logic [1:0]                id_bp_predict;
    logic [XLEN-1:0]           opA;
    logic [XLEN-1:0]           opB;

    logic [XLEN-1:0]           bu_nxt_pc;
    logic                      bu_flush;
    logic                      bu_cacheflush;
    logic                      bu_misaligned;
    logic [1:0]                bu_bp_predict;
    logic                      bu_bp_btaken;
    logic                      bu_bp_update;
    logic [BP_GLOBAL_BITS-1:0] bu_bp_history;
    logic [XLEN-1:0]           ras_top;
    logic                      ras_empty;
    logic                      ras_full;

    modport slave (
        input  ex_stall, st_flush, du_stall, du_we_pc, du_dato, id_bubble, id_pc, id_instr,
               id_is_rvc, id_bp_predict, opA, opB,
        output bu_nxt_pc, bu_flush, bu_cacheflush, bu_misaligned, bu_bp_predict, bu_bp_btaken,
               bu_bp_update, bu_bp_history, ras_top, ras_empty, ras_full
    );

    modport master (
        output ex_stall, st_flush, du_stall, du_we_pc, du_dato, id_bubble, id_pc, id_instr,
               id_is_rvc, id_bp_predict, opA, opB,
        input  bu_nxt_pc, bu_flush, bu_cacheflush, bu_misaligned, bu_bp_predict, bu_bp_btaken,
               bu_bp_update, bu_bp_history, ras_top, ras_empty, ras_full
    );
endinterface

// File: rtl/pu_riscv_bu_ras.sv
// EX-stage branch unit: resolves JAL/JALR/Bxx/FENCE.I, redirects IF, and keeps a circular
// return-address stack so predicted returns do not flush the pipeline.
module pu_riscv_bu_ras #(
    parameter int unsigned XLEN           = 64,
    parameter logic [63:0] PC_INIT        = 64'h8000_0000,
    parameter int unsigned BP_GLOBAL_BITS = 2,
    parameter int unsigned HAS_RVC        = 1,
    parameter int unsigned RAS_DEPTH      = 8
) (
    input logic              clk,
    input logic              rstn,
    pu_riscv_bu_ras_if.slave bu
);
    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
    localparam int unsigned HW = BP_GLOBAL_BITS + 1;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_BR   = 7'b1100011;
    localparam logic [6:0] OPC_MISC = 7'b0001111;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd, rs1;
    logic            is_jal, is_jalr, is_br, is_fencei;
    logic            rd_link, rs1_link, push, pop, br_taken, valid;
    logic [XLEN-1:0] seq, imm_j, imm_b, jalr_sum, top_c;

    assign opcode   = bu.id_instr[6:0];
    assign funct3   = bu.id_instr[14:12];
    assign rd       = bu.id_instr[11:7];
    assign rs1      = bu.id_instr[19:15];
    assign is_jal   = (opcode == OPC_JAL);
    assign is_jalr  = (opcode == OPC_JALR);
    assign is_br    = (opcode == OPC_BR) && (funct3[2:1] != 2'b01);
    assign is_fencei = (opcode == OPC_MISC) && (funct3 == 3'b001);
    assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
    assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
    // rd==rs1 (both link) is a coroutine-style push only; differing links pop then push
    assign push     = (is_jal || is_jalr) && rd_link;
    assign pop      = is_jalr && rs1_link && (!rd_link || (rd != rs1));

    assign seq      = bu.id_pc + (((HAS_RVC != 0) && bu.id_is_rvc) ? XLEN'(2) : XLEN'(4));
    assign imm_j    = {{(XLEN-20){bu.id_instr[31]}}, bu.id_instr[19:12], bu.id_instr[20],
                       bu.id_instr[30:21], 1'b0};
    assign imm_b    = {{(XLEN-12){bu.id_instr[31]}}, bu.id_instr[7], bu.id_instr[30:25],
                       bu.id_instr[11:8], 1'b0};
    assign jalr_sum = bu.opA + bu.opB;

    // state
    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d, ras_wa;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [HW-1:0]   hist_q, hist_d;
    logic            ras_we;
    logic [XLEN-1:0] nxt_pc_q, nxt_pc_d;
    logic            flush_q, flush_d, cf_q, cf_d, mis_q, mis_d;
    logic            bt_q, bt_d, upd_q, upd_d;
    logic [1:0]      pred_q, pred_d;

    assign top_c = (cnt_q == '0) ? '0 : ras_q[ptr_q];
    assign valid = !bu.id_bubble && !bu.du_stall && !bu.st_flush && !flush_q;

    always_comb begin : branch_cond
        case (funct3)
            3'b000:  br_taken = (bu.opA == bu.opB);
            3'b001:  br_taken = (bu.opA != bu.opB);
            3'b100:  br_taken = ($signed(bu.opA) <  $signed(bu.opB));
            3'b101:  br_taken = ($signed(bu.opA) >= $signed(bu.opB));
            3'b110:  br_taken = (bu.opA <  bu.opB);
            3'b111:  br_taken = (bu.opA >= bu.opB);
            default: br_taken = 1'b0;
        endcase
    end

    logic [XLEN-1:0] res_tgt;
    logic            res_taken, res_flush, res_cf, res_upd, res_mis;

    always_comb begin : resolve
        res_tgt   = seq;
        res_taken = 1'b0;
        res_flush = 1'b0;
        res_cf    = 1'b0;
        res_upd   = 1'b0;
        if (is_jal) begin
            res_tgt   = bu.id_pc + imm_j;
            res_taken = 1'b1;
        end else if (is_jalr) begin
            res_tgt   = {jalr_sum[XLEN-1:1], 1'b0};
            res_taken = 1'b1;
            res_flush = !(pop && (cnt_q != '0) && (top_c == {jalr_sum[XLEN-1:1], 1'b0}));
        end else if (is_br) begin
            res_taken = br_taken;
            res_tgt   = br_taken ? (bu.id_pc + imm_b) : seq;
            res_upd   = 1'b1;
            res_flush = br_taken ^ bu.id_bp_predict[1];
        end else if (is_fencei) begin
            res_flush = 1'b1;
            res_cf    = 1'b1;
        end
        res_mis = res_taken && ((HAS_RVC != 0) ? res_tgt[0] : (|res_tgt[1:0]));
        if (res_mis) res_flush = 1'b0;
    end

    always_comb begin : next_state
        nxt_pc_d = nxt_pc_q;
        flush_d  = flush_q;
        cf_d     = cf_q;
        mis_d    = mis_q;
        pred_d   = pred_q;
        bt_d     = bt_q;
        upd_d    = upd_q;
        hist_d   = hist_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        ras_we   = 1'b0;
        ras_wa   = ptr_q;
        if (!bu.ex_stall) begin
            if (upd_q) hist_d = {hist_q[HW-2:0], bt_q};
            if (bu.du_we_pc) begin
                nxt_pc_d = bu.du_dato;
                flush_d  = 1'b1;
                cf_d     = 1'b0;
                mis_d    = 1'b0;
                pred_d   = 2'b00;
                bt_d     = 1'b0;
                upd_d    = 1'b0;
                hist_d   = '0;
                ptr_d    = '0;
                cnt_d    = '0;
            end else begin
                pred_d  = bu.id_bp_predict;
                flush_d = 1'b0;
                cf_d    = 1'b0;
                mis_d   = 1'b0;
                bt_d    = 1'b0;
                upd_d   = 1'b0;
                if (valid) begin
                    nxt_pc_d = res_tgt;
                    flush_d  = res_flush;
                    cf_d     = res_cf;
                    mis_d    = res_mis;
                    bt_d     = res_taken;
                    upd_d    = res_upd;
                    if (!res_mis) begin
                        if (pop && (cnt_q != '0)) begin
                            ptr_d = ptr_q - PW'(1);
                            cnt_d = cnt_q - CW'(1);
                        end
                        if (push) begin
                            ptr_d  = ptr_d + PW'(1);
                            ras_we = 1'b1;
                            ras_wa = ptr_d;
                            if (cnt_d != CW'(RAS_DEPTH)) cnt_d = cnt_d + CW'(1);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin : state_reg
        if (!rstn) begin
            nxt_pc_q <= XLEN'(PC_INIT);
            flush_q  <= 1'b1;
            cf_q     <= 1'b0;
            mis_q    <= 1'b0;
            pred_q   <= 2'b00;
            bt_q     <= 1'b0;
            upd_q    <= 1'b0;
            hist_q   <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
        end else begin
            nxt_pc_q <= nxt_pc_d;
            flush_q  <= flush_d;
            cf_q     <= cf_d;
            mis_q    <= mis_d;
            pred_q   <= pred_d;
            bt_q     <= bt_d;
            upd_q    <= upd_d;
            hist_q   <= hist_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin : ras_mem
        if (!rstn) begin
            for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
        end else if (ras_we) begin
            ras_q[ras_wa] <= seq;
        end
    end

    assign bu.bu_nxt_pc     = nxt_pc_q;
    assign bu.bu_flush      = flush_q;
    assign bu.bu_cacheflush = cf_q;
    assign bu.bu_misaligned = mis_q;
    assign bu.bu_bp_predict = pred_q;
    assign bu.bu_bp_btaken  = bt_q;
    assign bu.bu_bp_update  = upd_q;
    assign bu.bu_bp_history = hist_q[HW-1:1];
    assign bu.ras_top       = top_c;
    assign bu.ras_empty     = (cnt_q == '0);
    assign bu.ras_full      = (cnt_q == CW'(RAS_DEPTH));
endmodule

// File: tb/tb_pu_riscv_bu_ras.sv
// Bench for pu_riscv_bu_ras: directed scenarios plus randomized instruction mix against a
// queue-based reference model of the branch unit and return-address stack.
module tb_pu_riscv_bu_ras;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned BPG   = 2;
    localparam int unsigned DEPTH = 8;
    localparam logic [63:0] PCI   = 64'h8000_0000;
    localparam int K_ALU = 0, K_JAL = 1, K_JALR = 2, K_BR = 3, K_FENCEI = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    pu_riscv_bu_ras_if #(.XLEN(XLEN), .BP_GLOBAL_BITS(BPG)) bus ();

    pu_riscv_bu_ras #(
        .XLEN(XLEN), .PC_INIT(PCI), .BP_GLOBAL_BITS(BPG), .HAS_RVC(1), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rstn(rstn), .bu(bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [63:0] m_nxt;
    logic        m_flush, m_cf, m_mis, m_bt, m_upd;
    logic [1:0]  m_pred;
    logic [2:0]  m_hist;
    logic [63:0] ras[$];
    int          m_kind, m_rd, m_rs1;
    logic [63:0] m_imm;
    logic [2:0]  m_f3;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_jal(input int rd, input logic [63:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'(rd), 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input int rd, input int rs1, input logic [63:0] imm);
        return {imm[11:0], 5'(rs1), 3'b000, 5'(rd), 7'b1100111};
    endfunction

    function automatic logic [31:0] enc_br(input logic [2:0] f3, input logic [63:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic bit lnk(input int r);
        return (r == 1) || (r == 5);
    endfunction

    task automatic model_reset();
        m_nxt = PCI; m_flush = 1'b1; m_cf = 1'b0; m_mis = 1'b0;
        m_bt = 1'b0; m_upd = 1'b0; m_pred = 2'b00; m_hist = 3'b000;
        ras.delete();
    endtask

    task automatic clear_inputs();
        bus.ex_stall = 1'b0; bus.st_flush = 1'b0; bus.du_stall = 1'b0; bus.du_we_pc = 1'b0;
        bus.du_dato = '0; bus.id_bubble = 1'b1; bus.id_pc = '0; bus.id_instr = 32'h0000_0013;
        bus.id_is_rvc = 1'b0; bus.id_bp_predict = 2'b00; bus.opA = '0; bus.opB = '0;
        m_kind = K_ALU; m_rd = 0; m_rs1 = 0; m_imm = '0; m_f3 = 3'b000;
    endtask

    task automatic set_ins(input int kind, input int rd, input int rs1, input logic [63:0] imm,
                           input logic [2:0] f3, input logic [63:0] pc, input logic [63:0] opa,
                           input logic [63:0] opb, input logic rvc, input logic [1:0] pred);
        m_kind = kind; m_rd = rd; m_rs1 = rs1; m_imm = imm; m_f3 = f3;
        bus.id_bubble = 1'b0; bus.id_pc = pc; bus.opA = opa; bus.opB = opb;
        bus.id_is_rvc = rvc; bus.id_bp_predict = pred;
        case (kind)
            K_JAL:    bus.id_instr = enc_jal(rd, imm);
            K_JALR:   bus.id_instr = enc_jalr(rd, rs1, imm);
            K_BR:     bus.id_instr = enc_br(f3, imm);
            K_FENCEI: bus.id_instr = 32'h0000_100F;
            default:  bus.id_instr = 32'h0020_81B3;
        endcase
    endtask

    // One clock of expected behaviour, computed from the current inputs and model state
    task automatic model_eval();
        logic [63:0] seq, tgt, a, b;
        bit valid, taken, fl, call, ret;
        if (bus.ex_stall) return;
        if (m_upd) m_hist = {m_hist[1:0], m_bt};
        if (bus.du_we_pc) begin
            m_nxt = bus.du_dato; m_flush = 1'b1; m_cf = 1'b0; m_mis = 1'b0;
            m_pred = 2'b00; m_bt = 1'b0; m_upd = 1'b0; m_hist = 3'b000;
            ras.delete();
            return;
        end
        valid = !bus.id_bubble && !bus.du_stall && !bus.st_flush && !m_flush;
        m_pred = bus.id_bp_predict;
        m_flush = 1'b0; m_cf = 1'b0; m_mis = 1'b0; m_bt = 1'b0; m_upd = 1'b0;
        if (!valid) return;
        a = bus.opA; b = bus.opB;
        seq = bus.id_pc + (bus.id_is_rvc ? 64'd2 : 64'd4);
        tgt = seq; taken = 0; fl = 0;
        call = (m_kind == K_JAL || m_kind == K_JALR) && lnk(m_rd);
        ret  = (m_kind == K_JALR) && lnk(m_rs1) && !(lnk(m_rd) && m_rd == m_rs1);
        case (m_kind)
            K_JAL: begin tgt = bus.id_pc + m_imm; taken = 1; end
            K_JALR: begin
                tgt = a + b; tgt[0] = 1'b0; taken = 1;
                fl = !(ret && ras.size() > 0 && ras[$] == tgt);
            end
            K_BR: begin
                case (m_f3)
                    3'd0: taken = (a == b);
                    3'd1: taken = (a != b);
                    3'd4: taken = ($signed(a) < $signed(b));
                    3'd5: taken = ($signed(a) >= $signed(b));
                    3'd6: taken = (a < b);
                    default: taken = (a >= b);
                endcase
                tgt = taken ? bus.id_pc + m_imm : seq;
                m_upd = 1'b1;
                fl = (taken != m_pred[1]);
            end
            K_FENCEI: begin fl = 1; m_cf = 1'b1; end
            default: ;
        endcase
        m_nxt = tgt; m_bt = taken;
        m_mis = taken && tgt[0];
        if (m_mis) fl = 0;
        m_flush = fl;
        if (!m_mis) begin
            if (ret && ras.size() > 0) void'(ras.pop_back());
            if (call) begin
                ras.push_back(seq);
                if (ras.size() > DEPTH) void'(ras.pop_front());
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".nxt_pc"},  bus.bu_nxt_pc, m_nxt);
        chk({tag, ".flush"},   64'(bus.bu_flush), 64'(m_flush));
        chk({tag, ".cflush"},  64'(bus.bu_cacheflush), 64'(m_cf));
        chk({tag, ".misal"},   64'(bus.bu_misaligned), 64'(m_mis));
        chk({tag, ".pred"},    64'(bus.bu_bp_predict), 64'(m_pred));
        chk({tag, ".btaken"},  64'(bus.bu_bp_btaken), 64'(m_bt));
        chk({tag, ".update"},  64'(bus.bu_bp_update), 64'(m_upd));
        chk({tag, ".history"}, 64'(bus.bu_bp_history), 64'(m_hist[2:1]));
        chk({tag, ".ras_top"}, bus.ras_top, (ras.size() > 0) ? ras[$] : 64'd0);
        chk({tag, ".empty"},   64'(bus.ras_empty), 64'(ras.size() == 0));
        chk({tag, ".full"},    64'(bus.ras_full), 64'(ras.size() == DEPTH));
    endtask

    task automatic step(input string tag);
        model_eval();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        clear_inputs();
        step(tag);
    endtask

    int regs[4] = '{0, 1, 5, 3};
    int f3s[6]  = '{0, 1, 4, 5, 6, 7};

    initial begin
        logic [63:0] pcs[9];
        logic [63:0] imm, pc, opa, opb;
        logic [20:0] r21;
        logic [12:0] r13;
        logic [11:0] r12;
        int kind;

        rstn = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        chk("reset.flush_k", 64'(bus.bu_flush), 64'd1);
        chk("reset.pc_k", bus.bu_nxt_pc, 64'h8000_0000);
        rstn = 1'b1;
        step("post_rst");
        chk("post_rst.flush_k", 64'(bus.bu_flush), 64'd0);

        set_ins(K_JAL, 1, 0, 64'h100, 3'd0, 64'h1000, '0, '0, 1'b0, 2'b00);
        step("jal");
        chk("jal.top_k", bus.ras_top, 64'h1004);
        chk("jal.nxt_k", bus.bu_nxt_pc, 64'h1100);
        set_ins(K_JALR, 0, 1, 64'h0, 3'd0, 64'h1100, 64'h1004, 64'h0, 1'b0, 2'b00);
        step("ret");
        chk("ret.flush_k", 64'(bus.bu_flush), 64'd0);
        chk("ret.nxt_k", bus.bu_nxt_pc, 64'h1004);
        chk("ret.empty_k", 64'(bus.ras_empty), 64'd1);

        set_ins(K_BR, 0, 0, 64'h40, 3'd0, 64'h2000, 64'd5, 64'd5, 1'b0, 2'b00);
        step("beq");
        chk("beq.nxt_k", bus.bu_nxt_pc, 64'h2040);
        chk("beq.flush_k", 64'(bus.bu_flush), 64'd1);
        chk("beq.bt_k", 64'(bus.bu_bp_btaken), 64'd1);
        chk("beq.upd_k", 64'(bus.bu_bp_update), 64'd1);
        idle("beq_shadow");

        set_ins(K_ALU, 0, 0, 64'h0, 3'd0, 64'h3000, '0, '0, 1'b1, 2'b00);
        step("rvc_add");
        chk("rvc_add.nxt_k", bus.bu_nxt_pc, 64'h3002);
        set_ins(K_JALR, 0, 6, 64'h0, 3'd0, 64'h3002, 64'h3001, 64'h0, 1'b0, 2'b00);
        step("jalr_odd");
        chk("jalr_odd.nxt_k", bus.bu_nxt_pc, 64'h3000);
        chk("jalr_odd.mis_k", 64'(bus.bu_misaligned), 64'd0);
        idle("jalr_shadow");

        for (int i = 0; i < 9; i++) begin
            pcs[i] = 64'h5000 + 64'(i) * 64'h10;
            set_ins(K_JAL, 1, 0, 64'h40, 3'd0, pcs[i], '0, '0, 1'b0, 2'b00);
            step("call");
        end
        chk("calls.full_k", 64'(bus.ras_full), 64'd1);
        for (int j = 0; j < 9; j++) begin
            set_ins(K_JALR, 0, 1, 64'h0, 3'd0, 64'h6000 + 64'(j) * 64'h4,
                    pcs[8-j] + 64'd4, 64'h0, 1'b0, 2'b00);
            step("ret_deep");
            chk("ret_deep.flush_k", 64'(bus.bu_flush), (j == 8) ? 64'd1 : 64'd0);
            chk("ret_deep.nxt_k", bus.bu_nxt_pc, pcs[8-j] + 64'd4);
        end
        idle("deep_shadow");

        set_ins(K_JAL, 1, 0, 64'h20, 3'd0, 64'h7000, '0, '0, 1'b0, 2'b00);
        step("du_call");
        set_ins(K_JALR, 0, 1, 64'h0, 3'd0, 64'h7020, 64'h7004, 64'h0, 1'b0, 2'b00);
        bus.du_we_pc = 1'b1; bus.du_stall = 1'b1; bus.du_dato = 64'h4000;
        step("du_wr");
        chk("du_wr.nxt_k", bus.bu_nxt_pc, 64'h4000);
        chk("du_wr.flush_k", 64'(bus.bu_flush), 64'd1);
        chk("du_wr.empty_k", 64'(bus.ras_empty), 64'd1);
        bus.du_we_pc = 1'b0;
        step("du_hold");
        chk("du_hold.nxt_k", bus.bu_nxt_pc, 64'h4000);
        chk("du_hold.flush_k", 64'(bus.bu_flush), 64'd0);
        idle("du_done");

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                rstn = 1'b0;
                #1;
                model_reset();
                check_outputs("async_rst");
                @(posedge clk);
                #1;
                rstn = 1'b1;
            end
            kind = int'($urandom_range(0, 4));
            pc = {32'h0, 32'($urandom)} & ~64'h1;
            if ($urandom_range(0, 9) == 0) pc[0] = 1'b1;
            opa = {32'($urandom), 32'($urandom)};
            opb = {32'($urandom), 32'($urandom)};
            imm = '0;
            case (kind)
                K_JAL: begin
                    r21 = 21'($urandom); r21[0] = 1'b0;
                    imm = {{43{r21[20]}}, r21};
                end
                K_JALR: begin
                    r12 = 12'($urandom);
                    imm = {{52{r12[11]}}, r12};
                    opb = imm;
                    if (ras.size() > 0 && $urandom_range(0, 1) == 1)
                        opa = ras[$] - opb + 64'($urandom_range(0, 1));
                end
                K_BR: begin
                    r13 = 13'($urandom); r13[0] = 1'b0;
                    imm = {{51{r13[12]}}, r13};
                    opa = 64'($urandom_range(0, 3)) - 64'd2;
                    opb = 64'($urandom_range(0, 3)) - 64'd2;
                end
                default: ;
            endcase
            set_ins(kind, regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)], imm,
                    3'(f3s[$urandom_range(0, 5)]), pc, opa, opb,
                    1'($urandom_range(0, 1)), 2'($urandom));
            bus.id_bubble = ($urandom_range(0, 9) == 0);
            bus.st_flush  = ($urandom_range(0, 19) == 0);
            bus.du_stall  = ($urandom_range(0, 19) == 0);
            bus.ex_stall  = ($urandom_range(0, 9) == 0);
            bus.du_we_pc  = ($urandom_range(0, 32) == 0);
            bus.du_dato   = {32'($urandom), 32'($urandom)};
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
